// File: rtl/mips_core_pkg.sv
// Shared MIPS core types: branch direction, branch-queue entry layout,
// and the delay-slot fall-through offset used for mispredict redirects.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;

    localparam int BFQ_ADDR_W = `ADDR_WIDTH;

    // Branch PC plus delay slot gives the not-taken fall-through address.
    localparam int DELAY_SLOT_OFFSET = 8;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    typedef struct packed {
        logic [BFQ_ADDR_W-1:0] pc;
        logic [BFQ_ADDR_W-1:0] target;
        BranchOutcome          dir;
    } bfq_entry_t;

endpackage

// File: rtl/bfq_storage.sv
// Entry array for the branch feedback queue: one write port, one
// combinational read port. Ports: clk, i_we/i_waddr/i_wdata, i_raddr/o_rdata.
module bfq_storage
    import mips_core_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  bfq_entry_t               i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output bfq_entry_t               o_rdata
);

    // Contents are don't-care after reset; validity lives in the count.
    bfq_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/branch_feedback_queue.sv
// In-order queue of in-flight branches pairing fetch predictions with EX
// resolution; drives predictor feedback and mispredict redirect.
// Ports: clk, rst (sync, active-high); i_pred_* enqueue, o_full;
// i_res_* resolve head; i_flush clears queue; o_fb_* registered feedback;
// o_redirect_* registered redirect; o_count occupancy.
// Optional macro BFQ_STATS_EN adds o_stat_resolved / o_stat_mispredict.
module branch_feedback_queue
    import mips_core_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = `ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_pred_valid,
    input  logic [ADDR_W-1:0]      i_pred_pc,
    input  logic [ADDR_W-1:0]      i_pred_target,
    input  BranchOutcome           i_pred_dir,
    output logic                   o_full,
    input  logic                   i_res_valid,
    input  BranchOutcome           i_res_outcome,
    input  logic                   i_flush,
    output logic                   o_fb_valid,
    output logic [ADDR_W-1:0]      o_fb_pc,
    output BranchOutcome           o_fb_prediction,
    output BranchOutcome           o_fb_outcome,
    output logic                   o_redirect_valid,
    output logic [ADDR_W-1:0]      o_redirect_pc,
    output logic [$clog2(DEPTH):0] o_count
`ifdef BFQ_STATS_EN
    ,
    output logic [31:0]            o_stat_resolved,
    output logic [31:0]            o_stat_mispredict
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic [PTR_W-1:0] w_head_nxt;
    logic [PTR_W-1:0] w_tail_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [PTR_W-1:0] w_head_inc;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_mispred;
    logic [ADDR_W-1:0] w_head_pc;
    logic [ADDR_W-1:0] w_head_tgt;
    logic [ADDR_W-1:0] w_redir_pc;

    bfq_entry_t       w_wr_entry;
    bfq_entry_t       w_rd_entry;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign o_full  = w_full;
    assign o_count = r_count;

    // A flush cancels both resolve and enqueue for this cycle.
    assign w_pop     = i_res_valid && !w_empty && !i_flush;
    assign w_mispred = w_pop && (w_rd_entry.dir != i_res_outcome);
    // Enqueue is blocked by full, flush and a mispredict squash
    // (the new entry would be on the wrong path).
    assign w_push    = i_pred_valid && !w_full && !i_flush && !w_mispred;

    assign w_head_inc = r_head + PTR_W'(1);

    assign w_wr_entry.pc     = BFQ_ADDR_W'(i_pred_pc);
    assign w_wr_entry.target = BFQ_ADDR_W'(i_pred_target);
    assign w_wr_entry.dir    = i_pred_dir;

    assign w_head_pc  = ADDR_W'(w_rd_entry.pc);
    assign w_head_tgt = ADDR_W'(w_rd_entry.target);
    assign w_redir_pc = (i_res_outcome == TAKEN)
                      ? w_head_tgt
                      : w_head_pc + ADDR_W'(DELAY_SLOT_OFFSET);

    bfq_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_tail),
        .i_wdata (w_wr_entry),
        .i_raddr (r_head),
        .o_rdata (w_rd_entry)
    );

    always_comb begin
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        w_count_nxt = r_count;
        if (i_flush) begin
            w_tail_nxt  = r_head;
            w_count_nxt = '0;
        end else if (w_mispred) begin
            // Popped head is gone, everything younger is wrong-path.
            w_head_nxt  = w_head_inc;
            w_tail_nxt  = w_head_inc;
            w_count_nxt = '0;
        end else begin
            if (w_pop) begin
                w_head_nxt = w_head_inc;
            end
            if (w_push) begin
                w_tail_nxt = r_tail + PTR_W'(1);
            end
            w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_fb_valid       <= 1'b0;
            o_fb_pc          <= '0;
            o_fb_prediction  <= NOT_TAKEN;
            o_fb_outcome     <= NOT_TAKEN;
            o_redirect_valid <= 1'b0;
            o_redirect_pc    <= '0;
        end else begin
            o_fb_valid       <= w_pop;
            o_redirect_valid <= w_mispred;
            if (w_pop) begin
                o_fb_pc         <= w_head_pc;
                o_fb_prediction <= w_rd_entry.dir;
                o_fb_outcome    <= i_res_outcome;
            end
            if (w_mispred) begin
                o_redirect_pc <= w_redir_pc;
            end
        end
    end

`ifdef BFQ_STATS_EN
    logic [31:0] r_stat_resolved;
    logic [31:0] r_stat_mispredict;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_resolved   <= '0;
            r_stat_mispredict <= '0;
        end else begin
            if (w_pop && (r_stat_resolved != '1)) begin
                r_stat_resolved <= r_stat_resolved + 32'd1;
            end
            if (w_mispred && (r_stat_mispredict != '1)) begin
                r_stat_mispredict <= r_stat_mispredict + 32'd1;
            end
        end
    end

    assign o_stat_resolved   = r_stat_resolved;
    assign o_stat_mispredict = r_stat_mispredict;
`endif

endmodule
